// File: rtl/ram1p_burst_ctrl_if.sv
// Command, write-data and read-data channels between a burst requester and ram1p_burst_ctrl.
interface ram1p_burst_ctrl_if #(
    parameter int AW    = 6,
    parameter int WIDTH = 128,
    parameter int LW    = 2
);
    localparam int BW = (WIDTH - 1) / 8 + 1;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [LW-1:0]    req_len;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [WIDTH-1:0] wdata;
    logic [BW-1:0]    wbe;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [WIDTH-1:0] rdata;
    logic             rdata_last;

    modport master (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, wbe, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, wbe, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last
    );
endinterface

// File: rtl/ram1p_burst_ctrl.sv
// Burst sequencer for a single-port byte-writable SRAM with a 2-entry read skid buffer.
// Define RAM1P_BURST_ZERO_INIT_EN to zero-fill the whole array after reset.
module ram1p_burst_ctrl #(
    parameter int  DEPTH    = 64,
    parameter int  WIDTH    = 128,
    parameter int  MAXBEATS = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = (WIDTH - 1) / 8 + 1,
    localparam int LW       = $clog2(MAXBEATS)
) (
    input  logic                     clk,
    input  logic                     reset,
    ram1p_burst_ctrl_if.slave        bus,
    output logic                     init_done,
    output logic                     ram_ce,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [WIDTH-1:0]         ram_din,
    output logic [BW-1:0]            ram_bwe,
    input  logic [WIDTH-1:0]         ram_dout
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    addr_reg, addr_next, addr_inc;
    logic [LW-1:0]    cnt_reg, cnt_next;
    logic             init_done_reg, init_done_next;
    logic             inflight_reg, inflight_next;
    logic             inflight_last_reg, inflight_last_next;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic [1:0]       occ_reg;
`ifdef RAM1P_BURST_ZERO_INIT_EN
    logic [AW-1:0]    init_cnt_reg, init_cnt_next;
`endif

    logic             rdata_valid_c, pop;
    logic             req_ready_c, wdata_ready_c, ce_c, we_c;
    logic [AW-1:0]    ram_addr_c;
    logic [WIDTH-1:0] ram_din_c;
    logic [BW-1:0]    ram_bwe_c;

    assign addr_inc      = (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);
    assign rdata_valid_c = (occ_reg != 2'd0);
    assign pop           = rdata_valid_c & bus.rdata_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= S_INIT;
            addr_reg          <= '0;
            cnt_reg           <= '0;
            init_done_reg     <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
            occ_reg           <= 2'd0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            cnt_reg           <= cnt_next;
            init_done_reg     <= init_done_next;
            inflight_reg      <= inflight_next;
            inflight_last_reg <= inflight_last_next;
            if (inflight_reg)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            // Capture and pop in the same cycle cancel out.
            occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

`ifdef RAM1P_BURST_ZERO_INIT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            init_cnt_reg <= '0;
        else
            init_cnt_reg <= init_cnt_next;
    end
`endif

    // Skid entries hold no reset: occupancy alone decides what is valid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
        logic [WIDTH-1:0] data_reg;
        logic             last_reg;
        always_ff @(posedge clk) begin
            if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= ram_dout;
                last_reg <= inflight_last_reg;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        addr_next          = addr_reg;
        cnt_next           = cnt_reg;
        init_done_next     = init_done_reg;
        inflight_next      = 1'b0;
        inflight_last_next = inflight_last_reg;
`ifdef RAM1P_BURST_ZERO_INIT_EN
        init_cnt_next      = init_cnt_reg;
`endif
        req_ready_c        = 1'b0;
        wdata_ready_c      = 1'b0;
        ce_c               = 1'b0;
        we_c               = 1'b0;
        ram_addr_c         = addr_reg;
        ram_din_c          = '0;
        ram_bwe_c          = '0;

        case (state_reg)
            S_INIT: begin
`ifdef RAM1P_BURST_ZERO_INIT_EN
                ce_c       = 1'b1;
                we_c       = 1'b1;
                ram_addr_c = init_cnt_reg;
                ram_bwe_c  = '1;
                if (init_cnt_reg == AW'(DEPTH - 1)) begin
                    state_next     = S_IDLE;
                    init_done_next = 1'b1;
                end else begin
                    init_cnt_next = init_cnt_reg + AW'(1);
                end
`else
                state_next     = S_IDLE;
                init_done_next = 1'b1;
`endif
            end
            S_IDLE: begin
                req_ready_c = init_done_reg & ~rdata_valid_c & ~inflight_reg;
                if (req_ready_c && bus.req_valid) begin
                    addr_next  = bus.req_addr;
                    cnt_next   = bus.req_len;
                    state_next = bus.req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wdata_ready_c = 1'b1;
                if (bus.wdata_valid) begin
                    ce_c      = 1'b1;
                    we_c      = 1'b1;
                    ram_din_c = bus.wdata;
                    ram_bwe_c = bus.wbe;
                    addr_next = addr_inc;
                    cnt_next  = cnt_reg - LW'(1);
                    if (cnt_reg == '0)
                        state_next = S_IDLE;
                end
            end
            S_READ: begin
                // Issue only if the result is guaranteed a skid slot on return.
                if ((occ_reg == 2'd0) || (occ_reg == 2'd1 && !inflight_reg) || pop) begin
                    ce_c               = 1'b1;
                    inflight_next      = 1'b1;
                    inflight_last_next = (cnt_reg == '0);
                    addr_next          = addr_inc;
                    cnt_next           = cnt_reg - LW'(1);
                    if (cnt_reg == '0)
                        state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!rdata_valid_c && !inflight_reg)
                    state_next = S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
    end

    assign bus.req_ready   = reset & req_ready_c;
    assign bus.wdata_ready = reset & wdata_ready_c;
    assign bus.rdata_valid = reset & rdata_valid_c;
    assign bus.rdata       = rd_ptr_reg ? g_skid[1].data_reg : g_skid[0].data_reg;
    assign bus.rdata_last  = reset & rdata_valid_c &
                             (rd_ptr_reg ? g_skid[1].last_reg : g_skid[0].last_reg);
    assign init_done       = reset & init_done_reg;
    assign ram_ce          = reset & ce_c;
    assign ram_we          = reset & we_c;
    assign ram_addr        = ram_addr_c;
    assign ram_din         = ram_din_c;
    assign ram_bwe         = reset ? ram_bwe_c : '0;
endmodule

// File: tb/tb_ram1p_burst_ctrl.sv
// Bench for ram1p_burst_ctrl: behavioural SRAM, golden word array, directed table and random bursts.
module tb_ram1p_burst_ctrl;
    localparam int DEPTH    = 64;
    localparam int WIDTH    = 128;
    localparam int MAXBEATS = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int BW       = (WIDTH - 1) / 8 + 1;
    localparam int LW       = $clog2(MAXBEATS);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram1p_burst_ctrl_if #(.AW(AW), .WIDTH(WIDTH), .LW(LW)) bus ();

    logic             init_done, ram_ce, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din, ram_dout;
    logic [BW-1:0]    ram_bwe;

    ram1p_burst_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAXBEATS(MAXBEATS)) dut (
        .clk(clk), .reset(reset), .bus(bus), .init_done(init_done),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_bwe(ram_bwe), .ram_dout(ram_dout)
    );

    // Behavioural single-port SRAM: one-cycle registered read, byte writes.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++)
                    if (ram_bwe[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    logic [WIDTH-1:0] gold [DEPTH];
    logic [WIDTH-1:0] wd   [MAXBEATS];
    logic [BW-1:0]    wb   [MAXBEATS];
    logic [WIDTH-1:0] got  [MAXBEATS];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void gold_write(input int a, input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++)
            if (be[b]) gold[a][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic reset_seq();
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0; bus.wbe = '0; bus.rdata_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("reset_outputs", {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last,
                              init_done, ram_ce, ram_we, ram_bwe}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef RAM1P_BURST_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("init_write", {ram_ce, ram_we, ram_addr, ram_bwe, init_done, bus.req_ready},
                              {1'b1, 1'b1, AW'(i), {BW{1'b1}}, 2'b00});
            chk("init_din", ram_din, '0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < DEPTH; i++) gold[i] = '0;
`else
        @(negedge clk);
        chk("init_no_access", {ram_ce, bus.req_ready}, 2'b00);
        @(posedge clk); #1;
`endif
        @(negedge clk);
        chk("init_done", {init_done, bus.req_ready, ram_ce}, 3'b110);
        @(posedge clk); #1;
        $display("RESET init complete at %0t", $time);
    endtask

    task automatic send_cmd(input bit w, input int a, input int len);
        int waitc = 0;
        bus.req_valid = 1'b1; bus.req_write = w;
        bus.req_addr = AW'(a); bus.req_len = LW'(len);
        @(negedge clk);
        while (!bus.req_ready && waitc < 100) begin
            @(posedge clk); #1; @(negedge clk); waitc++;
        end
        chk("cmd_accept", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wr_burst(input int a, input int len, input bit gaps);
        send_cmd(1'b1, a, len);
        for (int i = 0; i <= len; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.wdata_valid = 1'b0;
                @(negedge clk); chk("wr_gap_ce", ram_ce, 0);
                @(posedge clk); #1;
            end
            bus.wdata_valid = 1'b1; bus.wdata = wd[i]; bus.wbe = wb[i];
            @(negedge clk);
            chk("wr_ready", bus.wdata_ready, 1);
            chk("wr_ram_ctl", {ram_ce, ram_we, ram_addr, ram_bwe},
                              {1'b1, 1'b1, AW'((a + i) % DEPTH), wb[i]});
            chk("wr_ram_din", ram_din, wd[i]);
            @(posedge clk); #1;
            gold_write((a + i) % DEPTH, wd[i], wb[i]);
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk); chk("wr_end_idle", {bus.wdata_ready, ram_ce}, 2'b00);
        @(posedge clk); #1;
        $display("WR addr=%0d len=%0d gaps=%0d", a, len, gaps);
    endtask

    // mode 0: always ready, 1: toggling ready, 2: random ready
    task automatic rd_burst(input int a, input int len, input int mode);
        int issued = 0, popped = 0, k = 0;
        int first_ce = -1, last_ce = -1, first_pop = -1, last_pop = -1;
        bit stalled = 1'b0;
        logic [WIDTH:0] held = '0;
        send_cmd(1'b0, a, len);
        while (popped <= len && k < 200) begin
            case (mode)
                0:       bus.rdata_ready = 1'b1;
                1:       bus.rdata_ready = k[0];
                default: bus.rdata_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (ram_ce) begin
                chk("rd_ram_ctl", {ram_we, ram_addr}, {1'b0, AW'((a + issued) % DEPTH)});
                issued++;
                if (first_ce < 0) first_ce = k;
                last_ce = k;
            end
            if (stalled)
                chk("rd_stable", {bus.rdata_valid, bus.rdata_last, bus.rdata}, {1'b1, held});
            stalled = bus.rdata_valid && !bus.rdata_ready;
            held    = {bus.rdata_last, bus.rdata};
            if (bus.rdata_valid && bus.rdata_ready) begin
                chk("rd_data", bus.rdata, gold[(a + popped) % DEPTH]);
                chk("rd_last", bus.rdata_last, (popped == len));
                if (popped < MAXBEATS) got[popped] = bus.rdata;
                popped++;
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            if (ram_ce) chk("rd_occupancy", (issued - popped) <= 2, 1);
            @(posedge clk); #1;
            k++;
        end
        bus.rdata_ready = 1'b0;
        chk("rd_beats_done", popped, len + 1);
        chk("rd_beats_issued", issued, len + 1);
        if (mode == 0) begin
            chk("rd_ce_back_to_back", last_ce - first_ce, len);
            chk("rd_first_latency", first_pop - first_ce, 2);
            chk("rd_stream", last_pop - first_pop, len);
        end
        $display("RD addr=%0d len=%0d mode=%0d beats=%0d", a, len, mode, popped);
    endtask

    typedef struct {
        int               addr;
        logic [BW-1:0]    be;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_word;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, required finish earlier (checks=%0d)", $time, n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5,  16'h0001, {WIDTH{1'b1}}, 128'h00000000_00000000_00000000_000000FF};
        vecs[1] = '{6,  16'h8000, {WIDTH{1'b1}}, 128'hFF000000_00000000_00000000_00000000};
        vecs[2] = '{7,  16'h0000, {WIDTH{1'b1}}, 128'h0};
        vecs[3] = '{8,  16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                                  128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vecs[4] = '{9,  16'h00F0, 128'h00112233_44556677_8899AABB_CCDDEEFF,
                                  128'h00000000_00000000_8899AABB_00000000};
        vecs[5] = '{63, 16'h0300, {32{4'hA, 4'h5}}, 128'h00000000_0000A5A5_00000000_00000000};

        reset_seq();
`ifndef RAM1P_BURST_ZERO_INIT_EN
        for (int a = 0; a < DEPTH; a += MAXBEATS) begin
            for (int i = 0; i < MAXBEATS; i++) begin wd[i] = '0; wb[i] = '1; end
            wr_burst(a, MAXBEATS - 1, 1'b0);
        end
`endif

        // Single-word byte-enable vectors over a zeroed word.
        for (int v = 0; v < 6; v++) begin
            wd[0] = '0; wb[0] = '1;
            wr_burst(vecs[v].addr, 0, 1'b0);
            wd[0] = vecs[v].data; wb[0] = vecs[v].be;
            wr_burst(vecs[v].addr, 0, 1'b0);
            rd_burst(vecs[v].addr, 0, 0);
            chk("vec_readback", got[0], vecs[v].exp_word);
        end

        // Wrapping burst 62,63,0,1 then streamed and stalled reads.
        for (int i = 0; i < MAXBEATS; i++) begin
            wd[i] = {4{32'hD0D0_0000 + 32'(i)}}; wb[i] = '1;
        end
        wr_burst(62, 3, 1'b0);
        rd_burst(62, 3, 0);
        for (int i = 0; i < MAXBEATS; i++) chk("wrap_readback", got[i], {4{32'hD0D0_0000 + 32'(i)}});
        rd_burst(62, 3, 1);
        rd_burst(62, 3, 2);

        // Random bursts against the golden array.
        for (int t = 0; t < 40; t++) begin
            int a, len;
            a   = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(0, MAXBEATS - 1);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < MAXBEATS; i++) begin
                    wd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
                    wb[i] = ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom());
                end
                wr_burst(a, len, 1'($urandom_range(0, 1)));
            end else begin
                rd_burst(a, len, $urandom_range(0, 2));
            end
        end

        // Reset during beat 2 of a 4-beat write.
        for (int i = 0; i < MAXBEATS; i++) begin wd[i] = {4{32'hBEEF_0000 + 32'(i)}}; wb[i] = '1; end
        send_cmd(1'b1, 10, 3);
        for (int i = 0; i < 2; i++) begin
            bus.wdata_valid = 1'b1; bus.wdata = wd[i]; bus.wbe = wb[i];
            @(posedge clk); #1;
            gold_write(10 + i, wd[i], wb[i]);
        end
        bus.wdata = wd[2];
        reset = 1'b0;
        @(negedge clk); chk("midburst_reset_ce", ram_ce, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midburst_reset_state", {ram_ce, init_done, bus.wdata_ready, bus.req_ready, bus.rdata_valid}, '0);
        @(posedge clk); #1;
        reset_seq();
        rd_burst(10, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram1p_burst_ctrl.md
Name: ram1p_burst_ctrl

Overview:
- Initiator-side sequencer for a single-port byte-writable SRAM macro: registered address, read data valid the cycle after the address is sampled, per-byte write enables.
- Accepts burst read/write requests on a valid/ready command channel and issues one SRAM access per beat.
- Absorbs the 1-cycle read latency with a 2-entry read skid buffer so the consumer can apply backpressure.
- Optionally zero-fills the whole array after reset. Sits between cache/scratchpad control logic and the RAM instance.

Parameters:
- DEPTH, 64, number of RAM words; address width AW = $clog2(DEPTH).
- WIDTH, 128, bits per RAM word; byte-enable width BW = (WIDTH-1)/8+1.
- MAXBEATS, 4, maximum beats per burst (power of 2); length width LW = $clog2(MAXBEATS).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-low (reset==0 resets).
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when valid & ready.
- req_write  in  1  1=write burst, 0=read burst.
- req_addr  in  AW  start word address.
- req_len  in  LW  beats minus 1.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted.
- wdata  in  WIDTH  write beat data.
- wbe  in  BW  write beat byte enables.
- rdata_valid  out  1  read beat valid.
- rdata_ready  in  1  consumer accepts read beat.
- rdata  out  WIDTH  read beat data.
- rdata_last  out  1  final beat of burst.
- init_done  out  1  array initialised; commands allowed.
- ram_ce, ram_we  out  1  RAM chip enable, write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_bwe  out  BW  RAM byte write enables.
- ram_dout  in  WIDTH  RAM read data (valid the cycle after a read has ce=1).

Behaviour:
- States: INIT, IDLE, WRITE, READ, DRAIN. Reset enters INIT.
- Reset values: req_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, init_done=0, ram_ce=0, ram_we=0, ram_bwe=0. Read buffer is emptied and in-flight count cleared.
- Reset asserted mid-burst aborts the burst immediately and discards buffered data; no further RAM access is issued until INIT restarts.
- INIT:
  - ram_ce=ram_we=1, ram_bwe all ones, ram_din=0.
  - ram_addr counts 0..DEPTH-1, one word per cycle.
  - After the DEPTH-1 write: init_done=1 (sticky until reset), go to IDLE. INIT takes exactly DEPTH cycles.
- IDLE:
  - req_ready = init_done & read buffer empty & no read in flight.
  - On accept, latch addr, beat counter = req_len; go to WRITE or READ.
- WRITE:
  - wdata_ready=1.
  - Each cycle with wdata_valid: ram_ce=ram_we=1, ram_addr=current addr, ram_din=wdata, ram_bwe=wbe.
  - Addr increments modulo DEPTH (DEPTH-1 wraps to 0). Counter decrements.
  - Last beat returns to IDLE. wbe==0 still consumes a beat and a RAM cycle.
- READ:
  - Issue ram_ce=1, ram_we=0 when (occupancy + inflight < 2) or (rdata_valid & rdata_ready) this cycle.
  - The read result is captured from ram_dout into the buffer on the following edge, tagged with last = (beat counter was 0).
  - After issuing the final beat, go to DRAIN.
  - With rdata_ready held high, throughput is 1 beat/cycle. First rdata_valid appears 2 cycles after the first read ce.
- DRAIN: no RAM access; return to IDLE when buffer empty and nothing in flight.
- rdata/rdata_last come from the buffer head and are stable while rdata_valid & ~rdata_ready.
- Buffer never overflows; capture and pop in the same cycle keep occupancy unchanged.
- ram_ce=0 in every cycle not listed above; ram_we=0 whenever ram_ce=0.
- Commands presented during INIT are not accepted and are held by the requester.

Optional Feature:
- Macro: RAM1P_BURST_ZERO_INIT_EN.
- Defined: INIT zero-fill as above.
- Undefined: INIT lasts one cycle with no RAM access, init_done=1 on the first cycle after reset is released, and the array contents are undefined.

Test Plan:
- Reset then release (macro defined, DEPTH=64): 64 consecutive writes of 0 to addr 0..63 with bwe=all ones; init_done=1 in cycle 65; req_ready=1 after.
- Write req addr=62, len=3 with data D0..D3, wbe=all ones: RAM writes at 62,63,0,1; then read the same range returns D0..D3 with rdata_last only on D3.
- Write addr=5 with wbe=16'h0001, wdata=all ones over zeroed word: read back 128'h...00FF.
- Read len=3 with rdata_ready=1: one ce per cycle, 4 consecutive rdata_valid cycles, first 2 cycles after first ce.
- Read len=3 with rdata_ready toggling 0/1: never more than 2 buffered; data order and values preserved; rdata stable while stalled.
- Reset asserted at beat 2 of a 4-beat write: ram_ce=0 next cycle, INIT restarts, init_done=0 until INIT completes.
